// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the game I/O bridge.
// Holds the decoded address window, LFSR taps, channel-index width and default seed.
`timescale 1ns/1ps
package mmio_pkg;

  // Decoded data-memory addresses
  localparam logic [11:0] RAND_ADDR = 12'd5;
  localparam logic [11:0] LED_ADDR  = 12'd6;
  localparam logic [11:0] BTN_ADDR  = 12'd7;
  localparam logic [11:0] STAT_ADDR = 12'd8;

  // Fibonacci LFSR tap positions
  localparam int LFSR_TAP_A = 31;
  localparam int LFSR_TAP_B = 21;
  localparam int LFSR_TAP_C = 1;
  localparam int LFSR_TAP_D = 0;

  // Width of the channel-index field carried in data[4:1] of an LED store
  localparam int CH_IDX_W = 4;

  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_LIT  = 1'b1
  } ch_state_e;

  // One LFSR step; a nonzero state never maps to zero
  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return {r[30:0], r[LFSR_TAP_A] ^ r[LFSR_TAP_B] ^ r[LFSR_TAP_C] ^ r[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/mmio_game_io_led_flash_channel.sv
// led_flash_channel: one LED channel that stays lit for FLASH_CYCLES clocks per flash
// command. A new flash while lit restarts the full duration; an off command darkens it at once.
`timescale 1ns/1ps
module led_flash_channel
  import mmio_pkg::*;
#(
  parameter int FLASH_CYCLES = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic i_flash,
  input  logic i_off,
  output logic o_led,
  output logic o_busy
);

  localparam int CNT_W = $clog2(FLASH_CYCLES + 1);

  ch_state_e        r_state;
  ch_state_e        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // State and down-counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= CH_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: the counter holds the remaining lit cycles including the current one
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      CH_IDLE: begin
        if (i_flash) begin
          w_state_next = CH_LIT;
          w_cnt_next   = CNT_W'(FLASH_CYCLES);
        end
      end
      CH_LIT: begin
        if (i_flash) begin
          w_cnt_next = CNT_W'(FLASH_CYCLES);
        end else if (i_off || (r_cnt == CNT_W'(1))) begin
          w_state_next = CH_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = CH_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_led  = (r_state == CH_LIT);
  assign o_busy = (r_state == CH_LIT);

endmodule

// File: rtl/mmio_game_io.sv
// mmio_game_io: memory-mapped bridge between the processor data port and board game I/O.
// Provides an LFSR random source, NUM_CH flash-timed LEDs, sticky button latches and a
// busy register; every other address returns q_ram unchanged.
// Optional feature macro: MMIO_DEBOUNCE_EN adds a per-button debounce stage.
`timescale 1ns/1ps
module mmio_game_io
  import mmio_pkg::*;
#(
  parameter int          NUM_CH          = 4,
  parameter int          FLASH_CYCLES    = 50,
  parameter logic [31:0] SEED            = DEFAULT_SEED,
  parameter int          DEBOUNCE_CYCLES = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [11:0]       address_dmem,
  input  logic [31:0]       data,
  input  logic [31:0]       q_ram,
  output logic [31:0]       q_dmem,
  input  logic [NUM_CH-1:0] buttons,
  output logic [NUM_CH-1:0] leds
);

  if ((NUM_CH < 1) || (NUM_CH > 16) || (FLASH_CYCLES < 1) || (DEBOUNCE_CYCLES < 1) ||
      (SEED == 32'd0)) begin : g_bad_param
    $error("mmio_game_io: illegal parameter value");
  end

  logic [31:0]       r_lfsr;
  logic [NUM_CH-1:0] r_sync1;
  logic [NUM_CH-1:0] r_sync2;
  logic [NUM_CH-1:0] r_btn_prev;
  logic [NUM_CH-1:0] r_btn_latch;
  logic [NUM_CH-1:0] w_btn_level;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_clr;
  logic [NUM_CH-1:0] w_flash;
  logic [NUM_CH-1:0] w_off;
  logic [NUM_CH-1:0] w_busy;
  logic              w_led_wr;
  logic              w_btn_wr;

  assign w_led_wr = wren && (address_dmem == LED_ADDR);
  assign w_btn_wr = wren && (address_dmem == BTN_ADDR);

  // Free-running random source
  always_ff @(posedge clock) begin
    if (reset) r_lfsr <= SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  // One flash channel per LED; an out-of-range index matches no channel and is dropped
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_flash[gi] = w_led_wr && data[0] && (data[4:1] == CH_IDX_W'(gi));
    assign w_off[gi]   = w_led_wr && !data[0] && (data[4:1] == CH_IDX_W'(gi));

    led_flash_channel #(
      .FLASH_CYCLES (FLASH_CYCLES)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .i_flash (w_flash[gi]),
      .i_off   (w_off[gi]),
      .o_led   (leds[gi]),
      .o_busy  (w_busy[gi])
    );
  end

  // Two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_CH-1:0] r_deb_level;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_deb
    logic [DB_W-1:0] r_deb_cnt;

    // Debounced level follows the input only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clock) begin
      if (reset) begin
        r_deb_cnt       <= '0;
        r_deb_level[gi] <= 1'b0;
      end else if (r_sync2[gi] == r_deb_level[gi]) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        r_deb_cnt       <= '0;
        r_deb_level[gi] <= r_sync2[gi];
      end else begin
        r_deb_cnt <= r_deb_cnt + DB_W'(1);
      end
    end
  end

  assign w_btn_level = r_deb_level;
`else
  assign w_btn_level = r_sync2;
`endif

  assign w_rise = w_btn_level & ~r_btn_prev;
  assign w_clr  = w_btn_wr ? data[NUM_CH-1:0] : '0;

  // Edge detect and sticky latches; a new edge wins over a coincident clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_btn_prev  <= '0;
      r_btn_latch <= '0;
    end else begin
      r_btn_prev  <= w_btn_level;
      r_btn_latch <= (r_btn_latch & ~w_clr) | w_rise;
    end
  end

  // Combinational read mux over the decoded window
  always_comb begin
    q_dmem = q_ram;
    case (address_dmem)
      RAND_ADDR: q_dmem = r_lfsr;
      BTN_ADDR:  q_dmem = 32'(r_btn_latch);
      STAT_ADDR: q_dmem = 32'(w_busy);
      default:   q_dmem = q_ram;
    endcase
  end

endmodule

// File: tb/tb_mmio_game_io.sv
// tb_mmio_game_io: directed self-checking bench for mmio_game_io with default parameters.
`timescale 1ns/1ps
module tb_mmio_game_io;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wren = 1'b0;
  logic [11:0] address_dmem = 12'd100;
  logic [31:0] data = 32'd0;
  logic [31:0] q_ram = 32'hDEAD_BEEF;
  logic [31:0] q_dmem;
  logic [3:0]  buttons = 4'd0;
  logic [3:0]  leds;

  int n_checks = 0;
  int n_errors = 0;

  mmio_game_io dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .q_ram        (q_ram),
    .q_dmem       (q_dmem),
    .buttons      (buttons),
    .leds         (leds)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic read_at(input logic [11:0] a, output logic [31:0] v);
    address_dmem = a;
    #1;
    v = q_dmem;
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d);
    wren = 1'b1;
    address_dmem = a;
    data = d;
    tick();
    wren = 1'b0;
    data = 32'd0;
    address_dmem = 12'd100;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] m;
    int n;
    int zeros;

    // Reset and LFSR sequence
    tick();
    tick();
    reset = 1'b0;
    read_at(12'd5, v);
    check_eq("lfsr_c0", v, 32'hACE1_0001);
    tick();
    read_at(12'd5, v);
    check_eq("lfsr_c1", v, 32'h59C2_0003);
    tick();
    read_at(12'd5, v);
    check_eq("lfsr_c2", v, 32'hB384_0006);
    check_eq("leds_reset", 32'(leds), 32'h0);

    m = 32'hB384_0006;
    zeros = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]};
      if (q_dmem == 32'd0) zeros++;
    end
    check_eq("lfsr_1000", q_dmem, m);
    check_eq("lfsr_zero_cnt", 32'(zeros), 32'd0);

    read_at(12'd100, v);
    check_eq("ram_pass_a", v, 32'hDEAD_BEEF);

    // Single flash of channel 2
    store(12'd6, 32'h5);
    check_eq("flash_leds", 32'(leds), 32'h4);
    read_at(12'd8, v);
    check_eq("flash_stat", v, 32'h4);
    n = 0;
    while (leds[2] && n < 200) begin
      n++;
      tick();
    end
    check_eq("flash_len", 32'(n), 32'd50);
    check_eq("flash_done", 32'(leds), 32'h0);
    read_at(12'd8, v);
    check_eq("flash_stat_after", v, 32'h0);

    // Restart channel 0 at cycle 30
    store(12'd6, 32'h1);
    n = 0;
    while (leds[0] && n < 200) begin
      n++;
      if (n == 30) store(12'd6, 32'h1);
      else tick();
    end
    check_eq("restart_len", 32'(n), 32'd80);

    // Off command on channel 1
    store(12'd6, 32'h3);
    check_eq("ch1_on", 32'(leds), 32'h2);
    store(12'd6, 32'h2);
    check_eq("ch1_off", 32'(leds), 32'h0);

    // Back-to-back stores to channels 0 and 3
    store(12'd6, 32'h1);
    store(12'd6, 32'h7);
    check_eq("b2b_leds", 32'(leds), 32'h9);
    repeat (60) tick();
    check_eq("b2b_done", 32'(leds), 32'h0);

    // Out-of-range channel index
    store(12'd6, 32'h9);
    check_eq("badidx_leds", 32'(leds), 32'h0);
    read_at(12'd8, v);
    check_eq("badidx_stat", v, 32'h0);

    // Button pulse on channel 3
    buttons[3] = 1'b1;
    tick();
    buttons[3] = 1'b0;
    tick();
    read_at(12'd7, v);
    check_eq("btn_early", v, 32'h0);
    tick();
    read_at(12'd7, v);
    check_eq("btn_set", v, 32'h8);
    store(12'd7, 32'h8);
    read_at(12'd7, v);
    check_eq("btn_w1c", v, 32'h0);

    // Held button does not re-set a cleared latch
    buttons[3] = 1'b1;
    repeat (3) tick();
    read_at(12'd7, v);
    check_eq("hold_set", v, 32'h8);
    store(12'd7, 32'h8);
    repeat (5) tick();
    read_at(12'd7, v);
    check_eq("hold_stays_clr", v, 32'h0);

    // Clear coincident with a new edge: the edge wins
    buttons[3] = 1'b0;
    repeat (3) tick();
    buttons[3] = 1'b1;
    tick();
    tick();
    store(12'd7, 32'h8);
    read_at(12'd7, v);
    check_eq("w1c_vs_edge", v, 32'h8);
    buttons[3] = 1'b0;

    // Reset in the middle of a flash with latches set
    store(12'd6, 32'h3);
    buttons[0] = 1'b1;
    repeat (3) tick();
    buttons[0] = 1'b0;
    read_at(12'd7, v);
    check_eq("pre_rst_btn", v, 32'h9);
    check_eq("pre_rst_leds", 32'(leds), 32'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst_leds", 32'(leds), 32'h0);
    read_at(12'd5, v);
    check_eq("rst_lfsr", v, 32'hACE1_0001);
    read_at(12'd8, v);
    check_eq("rst_stat", v, 32'h0);
    read_at(12'd7, v);
    check_eq("rst_btn", v, 32'h0);

    // Store to the random address does not disturb the LFSR
    store(12'd5, 32'h0);
    read_at(12'd5, v);
    check_eq("rand_store_ignored", v, 32'h59C2_0003);

    q_ram = 32'h1234_5678;
    read_at(12'd100, v);
    check_eq("ram_pass_b", v, 32'h1234_5678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
